// File: rtl/univshift_pkg.sv
// Shared definitions for the universal shift register and its upstream sequencer.
package univshift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/univshift.sv
// Universal shift register: hold, shift right, shift left, parallel load; zero fill on shifts.
module univshift
  import univshift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cnt,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (cnt)
        MODE_SHR:  q <= {1'b0, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], 1'b0};
        MODE_LOAD: q <= in;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/univshift_seq.sv
// Parallel-in/serial-out sequencer: loads a handshaken word into univshift and
// shifts it out WIDTH times, tapping q for the serial bit.
module univshift_seq
  import univshift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_dir,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             pause,
  input  logic [WIDTH-1:0] q,
  output logic [1:0]       cnt,
  output logic [WIDTH-1:0] in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_dir;
  logic [WIDTH-1:0] r_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_LSB_FIRST;
      r_in    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_valid) begin
            r_in    <= s_data;
            r_dir   <= s_dir;
            r_cnt   <= '0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD:  r_state <= ST_SHIFT;
        ST_SHIFT: begin
          // Counter stops at LAST rather than wrapping on the exit edge.
          if (!pause) begin
            if (r_cnt == LAST) r_state <= ST_DONE;
            else               r_cnt   <= r_cnt + CW'(1);
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt       = MODE_HOLD;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    case (r_state)
      ST_LOAD:  cnt = MODE_LOAD;
      ST_SHIFT: begin
        ser_out   = (r_dir == DIR_MSB_FIRST) ? q[WIDTH-1] : q[0];
        ser_valid = ~pause;
        if (!pause) cnt = (r_dir == DIR_MSB_FIRST) ? MODE_SHL : MODE_SHR;
      end
      default:  cnt = MODE_HOLD;
    endcase
  end

  assign s_ready = (r_state == ST_IDLE);
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign in      = r_in;

endmodule

// File: tb/tb_univshift_seq.sv
// Directed bench: sequencer wired to the universal shift register as a PISO transmitter.
module tb_univshift_seq;

  logic       clk;
  logic       rst;
  logic [3:0] s_data;
  logic       s_dir;
  logic       s_valid;
  logic       s_ready;
  logic       pause;
  logic [3:0] q;
  logic [1:0] cnt;
  logic [3:0] in;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  univshift_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_dir(s_dir), .s_valid(s_valid),
    .s_ready(s_ready), .pause(pause), .q(q), .cnt(cnt), .in(in),
    .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done)
  );

  univshift #(.WIDTH(4)) sreg (
    .clk(clk), .rst(~rst), .cnt(cnt), .in(in), .q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {cnt, ser_valid, ser_out, done, busy, s_ready}
  logic [6:0] obs;
  assign obs = {cnt, ser_valid, ser_out, done, busy, s_ready};

  localparam logic [6:0] LD = 7'b11_0_0_0_1_0;
  localparam logic [6:0] R1 = 7'b01_1_1_0_1_0;
  localparam logic [6:0] R0 = 7'b01_1_0_0_1_0;
  localparam logic [6:0] L1 = 7'b10_1_1_0_1_0;
  localparam logic [6:0] L0 = 7'b10_1_0_0_1_0;
  localparam logic [6:0] P1 = 7'b00_0_1_0_1_0;
  localparam logic [6:0] DN = 7'b00_0_0_1_1_0;
  localparam logic [6:0] ID = 7'b00_0_0_0_0_1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; s_data = '0; s_dir = 1'b0; s_valid = 1'b0; pause = 1'b0;
    #1;
    checks++;
    if (obs !== ID) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs, ID);
    end
    step(); step();
    rst = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (obs !== ID) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", obs, ID);
    end
    step();
  endtask

  task automatic test_lsb_first();
    logic [6:0] ex [7];
    ex = '{LD, R1, R1, R0, R1, DN, ID};
    s_data = 4'b1011; s_dir = 1'b0; s_valid = 1'b1; pause = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== ID) begin failures++; $display("FAIL lsb_idle got=%b exp=%b", obs, ID); end
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== ex[k]) begin
        failures++;
        $display("FAIL lsb_first cyc=%0d got=%b exp=%b", k, obs, ex[k]);
      end
      step();
    end
  endtask

  task automatic test_msb_first();
    logic [6:0] ex [7];
    ex = '{LD, L1, L0, L1, L1, DN, ID};
    s_data = 4'b1011; s_dir = 1'b1; s_valid = 1'b1; pause = 1'b0;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== ex[k]) begin
        failures++;
        $display("FAIL msb_first cyc=%0d got=%b exp=%b", k, obs, ex[k]);
      end
      step();
    end
  endtask

  task automatic test_pause_mid();
    logic [6:0] ex [10];
    logic [9:0] pz;
    ex = '{LD, R0, P1, P1, P1, R1, R1, R0, DN, ID};
    pz = 10'b00_0001_1100;
    s_data = 4'b0110; s_dir = 1'b0; s_valid = 1'b1; pause = 1'b0;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pause = pz[k];
      @(negedge clk);
      checks++;
      if (obs !== ex[k]) begin
        failures++;
        $display("FAIL pause_mid cyc=%0d got=%b exp=%b", k, obs, ex[k]);
      end
      step();
    end
    pause = 1'b0;
  endtask

  task automatic test_pause_end();
    logic [6:0] ex [9];
    logic [8:0] pz;
    // Pause across the last bit, then held through DONE and into IDLE.
    ex = '{LD, L1, L0, L1, P1, P1, L1, DN, ID};
    pz = 9'b1_1011_0000;
    s_data = 4'b1011; s_dir = 1'b1; s_valid = 1'b1; pause = 1'b0;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      pause = pz[k];
      @(negedge clk);
      checks++;
      if (obs !== ex[k]) begin
        failures++;
        $display("FAIL pause_end cyc=%0d got=%b exp=%b", k, obs, ex[k]);
      end
      step();
    end
    pause = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] ex [15];
    logic [14:0] pz;
    ex = '{LD, R0, R1, R0, R1, DN, ID, LD, R1, R0, R1, R0, DN, ID, ID};
    pz = 15'b010_0000_0100_0000;
    s_data = 4'hA; s_dir = 1'b0; s_valid = 1'b1; pause = 1'b0;
    step();
    for (int k = 0; k < 15; k++) begin
      if (k == 0)  s_data  = 4'h5;
      if (k == 12) s_valid = 1'b0;
      pause = pz[k];
      @(negedge clk);
      checks++;
      if (obs !== ex[k]) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", k, obs, ex[k]);
      end
      step();
    end
    pause = 1'b0;
  endtask

  task automatic test_all_zero_ones();
    logic [6:0] ex [14];
    ex = '{LD, R0, R0, R0, R0, DN, ID, LD, R1, R1, R1, R1, DN, ID};
    s_data = 4'h0; s_dir = 1'b0; s_valid = 1'b1; pause = 1'b0;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k == 6) begin s_data = 4'hF; s_valid = 1'b1; end
      if (k == 7) s_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== ex[k]) begin
        failures++;
        $display("FAIL zero_ones cyc=%0d got=%b exp=%b", k, obs, ex[k]);
      end
      step();
    end
  endtask

  task automatic test_reset_midframe();
    s_data = 4'b1011; s_dir = 1'b0; s_valid = 1'b1; pause = 1'b0;
    step();
    s_valid = 1'b0;
    step();
    #1;
    checks++;
    if (obs !== R1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=%b", obs, R1); end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== ID) begin failures++; $display("FAIL rst_mid_async got=%b exp=%b", obs, ID); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== ID) begin
        failures++;
        $display("FAIL rst_mid_hold cyc=%0d got=%b exp=%b", k, obs, ID);
      end
    end
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_pause_mid();
    test_pause_end();
    test_back_to_back();
    test_all_zero_ones();
    test_reset_midframe();
    test_lsb_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
